rob_retire_unit: RTL

- Reader/consumer end of the reorder buffer. Holds the ROB entry array.
- Entries are written at the tail by dispatch and marked done by completion.
- Retires entries in order from the head to the architectural register file through a valid/ready handshake.
- Drives the head-advance pulse back to the ROB head/tail pointer allocator. Sits between the completion/writeback bus and the architectural register file.

---
 rtl/rob_pkg.sv | 29 ++
 rtl/rob_entry_array.sv | 115 +++++++++++
 rtl/rob_retire_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rob_pkg
//  Purpose  : Shared types and default sizes for the ROB retire unit slice.
//             rob_entry_t    - one reorder-buffer entry (default widths)
//             retire_state_e - retire FSM state (RUN / FLUSH)
//  Revision : 1.0  initial release
// ============================================================================
package rob_pkg;

    localparam int c_ROB_SIZE = 32;
    localparam int c_DATA_W   = 32;
    localparam int c_AREG_W   = 5;

    typedef struct packed {
        logic                valid;
        logic                done;
        logic                exc;
        logic [c_AREG_W-1:0] areg;
        logic [c_DATA_W-1:0] value;
    } rob_entry_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } retire_state_e;

endpackage : rob_pkg
`default_nettype wire

// File: rtl/rob_entry_array.sv
`default_nettype none
// ============================================================================
//  Module   : rob_entry_array
//  Purpose  : Reorder-buffer entry storage.  One alloc write port (tail),
//             one completion write port, one combinational head read port
//             and a clear-all of the valid/done/exc bits.
//  Ports    : clk_i, reset_i (async, active high)
//             alloc_en_i/alloc_tag_i/alloc_areg_i       - dispatch write
//             cmpl_en_i/cmpl_tag_i/cmpl_value_i/cmpl_exc_i - completion write
//             retire_en_i, head_i                       - retire clears head
//             clear_all_i                               - invalidate all
//             head_*_o                                  - entry[head_i] fields
//  Macro    : ROB_RETIRE_EXC_EN - store the per-entry exception bit
//  Revision : 1.0  initial release
// ============================================================================
module rob_entry_array
    import rob_pkg::*;
#(
    parameter int ROB_SIZE = c_ROB_SIZE,
    parameter int ADDR_W   = $clog2(ROB_SIZE),
    parameter int DATA_W   = c_DATA_W,
    parameter int AREG_W   = c_AREG_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              alloc_en_i,
    input  logic [ADDR_W-1:0] alloc_tag_i,
    input  logic [AREG_W-1:0] alloc_areg_i,
    input  logic              cmpl_en_i,
    input  logic [ADDR_W-1:0] cmpl_tag_i,
    input  logic [DATA_W-1:0] cmpl_value_i,
    input  logic              cmpl_exc_i,
    input  logic              retire_en_i,
    input  logic [ADDR_W-1:0] head_i,
    input  logic              clear_all_i,
    output logic              head_valid_o,
    output logic              head_done_o,
    output logic              head_exc_o,
    output logic [AREG_W-1:0] head_areg_o,
    output logic [DATA_W-1:0] head_value_o
);

    logic [ROB_SIZE-1:0] r_valid;
    logic [ROB_SIZE-1:0] r_done;
    logic [AREG_W-1:0]   r_areg  [ROB_SIZE];
    logic [DATA_W-1:0]   r_value [ROB_SIZE];

    // Completion is dropped when dispatch re-allocates the same tag this cycle.
    logic w_cmpl_wr;
    assign w_cmpl_wr = cmpl_en_i && r_valid[cmpl_tag_i] &&
                       !(alloc_en_i && (alloc_tag_i == cmpl_tag_i));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_valid <= '0;
            r_done  <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                r_areg[i]  <= '0;
                r_value[i] <= '0;
            end
        end else if (clear_all_i) begin
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            if (retire_en_i) begin
                r_valid[head_i] <= 1'b0;
            end
            if (w_cmpl_wr) begin
                r_done[cmpl_tag_i]  <= 1'b1;
                r_value[cmpl_tag_i] <= cmpl_value_i;
            end
            if (alloc_en_i) begin
                r_valid[alloc_tag_i] <= 1'b1;
                r_done[alloc_tag_i]  <= 1'b0;
                r_areg[alloc_tag_i]  <= alloc_areg_i;
            end
        end
    end

`ifdef ROB_RETIRE_EXC_EN
    logic [ROB_SIZE-1:0] r_exc;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_exc <= '0;
        end else if (clear_all_i) begin
            r_exc <= '0;
        end else begin
            if (w_cmpl_wr) begin
                r_exc[cmpl_tag_i] <= cmpl_exc_i;
            end
            if (alloc_en_i) begin
                r_exc[alloc_tag_i] <= 1'b0;
            end
        end
    end

    assign head_exc_o = r_exc[head_i];
`else
    logic w_unused_exc;
    assign w_unused_exc = cmpl_exc_i;
    assign head_exc_o   = 1'b0;
`endif

    assign head_valid_o = r_valid[head_i];
    assign head_done_o  = r_done[head_i];
    assign head_areg_o  = r_areg[head_i];
    assign head_value_o = r_value[head_i];

    // Dispatch must never overwrite a live entry (allocator stalls on full).
    a_alloc_free : assert property (@(posedge clk_i) disable iff (reset_i)
        alloc_en_i |-> !r_valid[alloc_tag_i]);

endmodule : rob_entry_array
`default_nettype wire

// File: rtl/rob_retire_unit.sv
`default_nettype none
// ============================================================================
//  Module   : rob_retire_unit
//  Purpose  : Consumer end of the reorder buffer.  Holds the entry array,
//             retires done entries in order from the head to the register
//             file over a valid/ready handshake and pulses update_head_o
//             back to the pointer allocator on every retire.
//  Ports    : clk_i, reset_i (async, active high)
//             alloc_*  - dispatch writes entry at allocator tail
//             cmpl_*   - completion/writeback bus
//             retire_* - valid/ready retire to architectural register file
//             update_head_o, head_o, empty_o, flush_o
//  Macro    : ROB_RETIRE_EXC_EN - an excepting head entry triggers a one-cycle
//             flush_o pulse and a FLUSH state that empties the ROB; without
//             it cmpl_exc_i is ignored and flush_o is tied 0.
//  Revision : 1.0  initial release
// ============================================================================
module rob_retire_unit
    import rob_pkg::*;
#(
    parameter int ROB_SIZE = c_ROB_SIZE,
    parameter int ADDR_W   = $clog2(ROB_SIZE),
    parameter int DATA_W   = c_DATA_W,
    parameter int AREG_W   = c_AREG_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              alloc_valid_i,
    input  logic [ADDR_W-1:0] alloc_tag_i,
    input  logic [AREG_W-1:0] alloc_areg_i,
    input  logic              cmpl_valid_i,
    input  logic [ADDR_W-1:0] cmpl_tag_i,
    input  logic [DATA_W-1:0] cmpl_value_i,
    input  logic              cmpl_exc_i,
    input  logic              retire_ready_i,
    output logic              retire_valid_o,
    output logic [AREG_W-1:0] retire_areg_o,
    output logic [DATA_W-1:0] retire_value_o,
    output logic              update_head_o,
    output logic [ADDR_W-1:0] head_o,
    output logic              empty_o,
    output logic              flush_o
);

    retire_state_e     r_state;
    retire_state_e     w_state_next;
    logic [ADDR_W-1:0] r_head;

    logic              w_head_valid;
    logic              w_head_done;
    logic              w_head_exc;
    logic [AREG_W-1:0] w_head_areg;
    logic [DATA_W-1:0] w_head_value;

    logic w_retire_valid;
    logic w_fire;
    logic w_flush;
    logic w_clear_all;
    logic w_accept;

    rob_entry_array #(
        .ROB_SIZE (ROB_SIZE),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .AREG_W   (AREG_W)
    ) u_entries (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .alloc_en_i   (alloc_valid_i && w_accept),
        .alloc_tag_i  (alloc_tag_i),
        .alloc_areg_i (alloc_areg_i),
        .cmpl_en_i    (cmpl_valid_i && w_accept),
        .cmpl_tag_i   (cmpl_tag_i),
        .cmpl_value_i (cmpl_value_i),
        .cmpl_exc_i   (cmpl_exc_i),
        .retire_en_i  (w_fire),
        .head_i       (r_head),
        .clear_all_i  (w_clear_all),
        .head_valid_o (w_head_valid),
        .head_done_o  (w_head_done),
        .head_exc_o   (w_head_exc),
        .head_areg_o  (w_head_areg),
        .head_value_o (w_head_value)
    );

    // Next state and per-cycle controls.  The entry array is cleared both on
    // the edge that raises flush_o and on the FLUSH edge, so the ROB already
    // looks empty in the cycle after flush_o while dispatch stays blocked.
    always_comb begin
        w_state_next   = r_state;
        w_retire_valid = 1'b0;
        w_flush        = 1'b0;
        w_clear_all    = 1'b0;
        w_accept       = 1'b1;
        case (r_state)
            RUN: begin
`ifdef ROB_RETIRE_EXC_EN
                if (w_head_valid && w_head_done && w_head_exc) begin
                    w_flush      = 1'b1;
                    w_clear_all  = 1'b1;
                    w_accept     = 1'b0;
                    w_state_next = FLUSH;
                end else begin
                    w_retire_valid = w_head_valid && w_head_done && !w_head_exc;
                end
`else
                w_retire_valid = w_head_valid && w_head_done && !w_head_exc;
`endif
            end
            FLUSH: begin
                w_clear_all  = 1'b1;
                w_accept     = 1'b0;
                w_state_next = RUN;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    assign w_fire = w_retire_valid && retire_ready_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Head wraps naturally because ROB_SIZE is a power of two.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_head <= '0;
        end else if (w_clear_all) begin
            r_head <= '0;
        end else if (w_fire) begin
            r_head <= r_head + ADDR_W'(1);
        end
    end

    assign retire_valid_o = w_retire_valid;
    assign retire_areg_o  = w_head_areg;
    assign retire_value_o = w_head_value;
    assign update_head_o  = w_fire;
    assign head_o         = r_head;
    assign empty_o        = !w_head_valid;
    assign flush_o        = w_flush;

endmodule : rob_retire_unit
`default_nettype wire
